// File: rtl/sseg_scan_n.sv
// Multiplexed seven-segment driver for DIGITS hex digits with per-digit
// blank/blink, leading-zero suppression, 16-level PWM brightness and
// frame-coherent shadowing of the display inputs. Exports the 1 ms enable.
module sseg_scan_n #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIGITS   = 4,
    parameter int BLINK_MS = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   dat,
    input  logic [DIGITS-1:0]     pt,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     act,
    output logic [7:0]            seg,
    output logic                  ce_1ms
);

    localparam int PRESC = CLK_FREQ / 1000;
    localparam int PW    = $clog2(PRESC);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW    = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic [PW-1:0]         presc_q, presc_d;
    logic                  ce_q, ce_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [3:0]            pwm_q, pwm_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic                  first_q, first_d;
    logic [4*DIGITS-1:0]   sh_dat_q, sh_dat_d;
    logic [DIGITS-1:0]     sh_pt_q, sh_pt_d;
    logic [DIGITS-1:0]     sh_blank_q, sh_blank_d;
    logic [DIGITS-1:0]     sh_blink_q, sh_blink_d;
    logic                  sh_lz_q, sh_lz_d;
    logic [DIGITS-1:0]     act_q, act_d;
    logic [7:0]            seg_q, seg_d;

    logic [DIGITS-1:0]     lz_mask;
    logic                  wrap;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Timebase: prescaler, 1 ms enable, scan index, PWM and blink counters.
    always_comb begin
        presc_d = (presc_q == PW'(PRESC - 1)) ? '0 : presc_q + PW'(1);
        ce_d    = (presc_q == PW'(PRESC - 1));
        pwm_d   = pwm_q + 4'd1;
        wrap    = ce_q && (idx_q == IW'(DIGITS - 1));
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (ce_q) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
            if (bcnt_q == BW'(BLINK_MS - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // Shadow copy of the display inputs, refreshed at frame start only.
    always_comb begin
        first_d    = 1'b0;
        sh_dat_d   = sh_dat_q;
        sh_pt_d    = sh_pt_q;
        sh_blank_d = sh_blank_q;
        sh_blink_d = sh_blink_q;
        sh_lz_d    = sh_lz_q;
        if (first_q || wrap) begin
            sh_dat_d   = dat;
            sh_pt_d    = pt;
            sh_blank_d = blank;
            sh_blink_d = blink;
            sh_lz_d    = lz_en;
        end
    end

    // Leading-zero mask: suppress from the top while digits are zero with no dp.
    always_comb begin
        logic run;
        int unsigned i;
        lz_mask = '0;
        run     = sh_lz_q;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            i = DIGITS - 1 - k;
            if (run && (sh_dat_q[4*i +: 4] == 4'h0) && !sh_pt_q[i]) begin
                lz_mask[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    // Output stage: select current digit, apply dark conditions, decode.
    always_comb begin
        logic [3:0] nib;
        logic       dp;
        logic       dark;
        nib   = '0;
        dp    = 1'b0;
        dark  = 1'b0;
        act_d = '0;
        seg_d = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib      = sh_dat_q[4*i +: 4];
                dp       = sh_pt_q[i];
                dark     = sh_blank_q[i] | lz_mask[i] | (sh_blink_q[i] & phase_q);
                act_d[i] = 1'b1;
            end
        end
        if (dark || (pwm_q > bright)) begin
            act_d = '0;
        end else begin
            seg_d = {dp, hex7(nib)};
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            ce_q       <= 1'b0;
            idx_q      <= '0;
            pwm_q      <= '0;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
            first_q    <= 1'b1;
            sh_dat_q   <= '0;
            sh_pt_q    <= '0;
            sh_blank_q <= '0;
            sh_blink_q <= '0;
            sh_lz_q    <= 1'b0;
            act_q      <= '0;
            seg_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            ce_q       <= ce_d;
            idx_q      <= idx_d;
            pwm_q      <= pwm_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            sh_dat_q   <= sh_dat_d;
            sh_pt_q    <= sh_pt_d;
            sh_blank_q <= sh_blank_d;
            sh_blink_q <= sh_blink_d;
            sh_lz_q    <= sh_lz_d;
            act_q      <= act_d;
            seg_q      <= seg_d;
        end
    end

    assign act    = act_q;
    assign seg    = seg_q;
    assign ce_1ms = ce_q;

endmodule

// File: tb/tb_sseg_scan_n.sv
// Bench for sseg_scan_n: directed scenarios plus random traffic, checked
// against a closed-form timing model (outputs as a function of clocks elapsed
// since reset release) and frame-start snapshots of the inputs.
module tb_sseg_scan_n;

    localparam int CLK_FREQ = 4000;
    localparam int DIGITS   = 4;
    localparam int BLINK_MS = 2;
    localparam int P        = CLK_FREQ / 1000;

    logic        clk;
    logic        rst_n;
    logic [15:0] dat;
    logic [3:0]  pt, blank, blink;
    logic        lz_en;
    logic [3:0]  bright;
    logic [3:0]  act;
    logic [7:0]  seg;
    logic        ce_1ms;

    int checks = 0;
    int errors = 0;

    // model state
    int          n;          // clock edges since reset release
    logic [15:0] m_dat;
    logic [3:0]  m_pt, m_blank, m_blink;
    logic        m_lz;
    logic [3:0]  e_act;
    logic [7:0]  e_seg;
    logic        e_ce;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sseg_scan_n #(.CLK_FREQ(CLK_FREQ), .DIGITS(DIGITS), .BLINK_MS(BLINK_MS)) dut (
        .clk(clk), .rst_n(rst_n), .dat(dat), .pt(pt), .blank(blank),
        .blink(blink), .lz_en(lz_en), .bright(bright),
        .act(act), .seg(seg), .ce_1ms(ce_1ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic int pulses(input int t);
        return (t == 0) ? 0 : (t - 1) / P;
    endfunction

    // One clock: predict outputs after this edge from state after the previous one.
    task automatic step();
        int t, d, top;
        logic ph, dark;
        @(posedge clk);
        t  = n;
        d  = pulses(t) % DIGITS;
        ph = ((pulses(t) / BLINK_MS) % 2) == 1;
        top = 0;
        for (int k = 0; k < DIGITS; k++)
            if (m_dat[4*k +: 4] != 4'h0 || m_pt[k]) top = k;
        dark = m_blank[d] || (m_blink[d] && ph) || ((t % 16) > int'(bright))
               || (m_lz && d > top);
        if (dark) begin
            e_act = 4'b0;
            e_seg = 8'h00;
        end else begin
            e_act = 4'b1 << d;
            e_seg = {m_pt[d], tbl[m_dat[4*d +: 4]]};
        end
        n = n + 1;
        if ((n - 1) % (P * DIGITS) == 0) begin
            m_dat = dat; m_pt = pt; m_blank = blank; m_blink = blink; m_lz = lz_en;
        end
        e_ce = (n % P) == 0;
        @(negedge clk);
        chk("act", 32'(act), 32'(e_act));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("ce_1ms", 32'(ce_1ms), 32'(e_ce));
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    // Assert reset away from a clock edge, check outputs clear at once, release at negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_act", 32'(act), 32'h0);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_ce", 32'(ce_1ms), 32'h0);
        n = 0;
        m_dat = '0; m_pt = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic bright_count(input logic [3:0] b);
        int cnt;
        bright = b;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (act != 4'b0) cnt++;
        end
        chk("bright_duty", 32'(cnt), 32'(int'(b) + 1));
    endtask

    initial begin
        int cnt1;
        rst_n = 1'b0;
        dat = 16'h1234; pt = '0; blank = '0; blink = '0; lz_en = 1'b0; bright = 4'd15;
        n = 0;
        @(negedge clk);
        do_reset();

        // basic scan of 1234 with first ce after P clocks
        steps(64);

        // reset mid-frame, then restart from digit 0
        steps(6);
        do_reset();
        steps(40);

        // leading-zero suppression, then dp keeps digit 3 lit
        lz_en = 1'b1; dat = 16'h0050; pt = 4'b0000;
        steps(40);
        pt = 4'b1000;
        steps(40);
        lz_en = 1'b0; pt = 4'b0000;

        // tear check: change data while digit 2 is being shown
        dat = 16'h1111;
        steps(20);
        while ((pulses(n) % DIGITS) != 2) step();
        dat = 16'h2222;
        steps(40);

        // brightness duty
        steps(20);
        bright_count(4'd3);
        bright_count(4'd0);
        bright_count(4'd15);

        // blink on digit 0, blank digit 1 at various brightness
        blink = 4'b0001; blank = 4'b0010;
        steps(20);
        cnt1 = 0;
        for (int i = 0; i < 120; i++) begin
            if (i == 60) bright = 4'd7;
            step();
            if (act[1]) cnt1++;
        end
        chk("blank_d1", 32'(cnt1), 32'h0);
        blink = '0; blank = '0; bright = 4'd15;

        // random traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                dat = 16'($urandom);
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 1) == 0) dat[4*k +: 4] = 4'h0;
                pt     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
                blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
                blink  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
                lz_en  = 1'($urandom);
                bright = ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom);
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
